// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one word per start strobe as start, LSB-first data, optional parity and stop bits,
// pacing each bit on the tick counter's bit_tick and realigning that counter with tick_load at frame start.
module uart_tx_framer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_tick,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tick_cs,
    output logic                 tick_load,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cs_q, cs_d;
    logic                 load_q, load_d;
    logic                 tick;
    // A tick landing on the realignment cycle belongs to the old period, so the start bit gets a full one.
    assign tick = bit_tick && !load_q;
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        load_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = START;
                shift_d = data_in;
                cnt_d   = '0;
                par_d   = (^data_in) ^ (PARITY_ODD != 0);
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                cs_d    = 1'b1;
                load_d  = 1'b1;
            end
            START: if (tick) begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end
            DATA: if (tick) begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 3'd1;
                tx_d    = shift_d[0];
                if (cnt_q == 3'(DATA_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    tx_d    = (PARITY_EN != 0) ? par_q : 1'b1;
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (tick) begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    cs_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            load_q  <= load_d;
        end
    end
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tick_cs   = cs_q;
    assign tick_load = load_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: five framer configurations driven by directed and random frames, checked against a bit-list model.
module tb_uart_tx_framer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_tick = 1'b0;
    logic [4:0] start_v = '0;
    logic [7:0] data_in = '0;
    logic [4:0] tx_w, busy_w, done_w, cs_w, load_w;
    int total = 0;
    int passed = 0;
    localparam int DB[5] = '{8, 8, 8, 8, 5};
    localparam int SB[5] = '{1, 1, 1, 2, 1};
    localparam int PE[5] = '{0, 1, 1, 0, 1};
    localparam int PO[5] = '{0, 0, 1, 0, 1};

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .start(start_v[0]), .data_in(data_in),
        .tick_cs(cs_w[0]), .tick_load(load_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .start(start_v[1]), .data_in(data_in),
        .tick_cs(cs_w[1]), .tick_load(load_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .start(start_v[2]), .data_in(data_in),
        .tick_cs(cs_w[2]), .tick_load(load_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .start(start_v[3]), .data_in(data_in),
        .tick_cs(cs_w[3]), .tick_load(load_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));
    uart_tx_framer #(.DATA_BITS(5), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u4 (
        .clk(clk), .reset(reset), .bit_tick(bit_tick), .start(start_v[4]), .data_in(data_in[4:0]),
        .tick_cs(cs_w[4]), .tick_load(load_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int frame_len(input int k);
        return 1 + DB[k] + PE[k] + SB[k];
    endfunction

    // Expected line level for bit period p of a frame carrying d.
    function automatic logic frame_bit(input int k, input logic [7:0] d, input int p);
        logic [7:0] m;
        m = d & 8'((1 << DB[k]) - 1);
        if (p == 0) return 1'b0;
        if (p <= DB[k]) return d[p-1];
        if (PE[k] != 0 && p == DB[k] + 1) return 1'(($countones(m) % 2) ^ PO[k]);
        return 1'b1;
    endfunction

    task automatic begin_frame(input int k, input logic [7:0] d);
        data_in = d;
        start_v[k] = 1'b1;
        step();
        start_v[k] = 1'b0;
        data_in = 8'($urandom);
        chk("accept_tx", tx_w[k], 0);
        chk("accept_busy", busy_w[k], 1);
        chk("accept_cs", cs_w[k], 1);
        chk("accept_load", load_w[k], 1);
        chk("accept_done", done_w[k], 0);
    endtask

    task automatic run_frame(input int k, input logic [7:0] d, input bit tick_at_load, input bit collide);
        int n;
        n = frame_len(k);
        bit_tick = tick_at_load;
        step();
        bit_tick = 1'b0;
        chk("load_pulse_end", load_w[k], 0);
        chk("start_bit_hold", tx_w[k], 0);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < 14; i++) begin
                if (collide && p == 3 && i == 5) begin
                    start_v[k] = 1'b1;
                    data_in = 8'h12;
                end
                step();
                start_v[k] = 1'b0;
                if (i == 7) begin
                    chk("mid_bit", tx_w[k], frame_bit(k, d, p));
                    chk("mid_busy", busy_w[k], 1);
                    chk("mid_done", done_w[k], 0);
                end
            end
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
            if (p < n - 1) begin
                chk("edge_bit", tx_w[k], frame_bit(k, d, p + 1));
                chk("edge_done", done_w[k], 0);
            end else begin
                chk("end_done", done_w[k], 1);
                chk("end_busy", busy_w[k], 0);
                chk("end_cs", cs_w[k], 0);
                chk("end_tx", tx_w[k], 1);
            end
        end
    endtask

    task automatic settle(input int k);
        step();
        chk("done_one_cycle", done_w[k], 0);
        chk("idle_tx", tx_w[k], 1);
    endtask

    initial begin
        logic [7:0] d;
        int k, prev;
        bit chain;
        start_v = '1;
        data_in = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            bit_tick = ~bit_tick;
            step();
            chk("rst_tx", tx_w, 5'h1F);
            chk("rst_busy", busy_w, 0);
            chk("rst_done", done_w, 0);
            chk("rst_cs", cs_w, 0);
            chk("rst_load", load_w, 0);
        end
        start_v = '0;
        bit_tick = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
            step();
            chk("idle_tick_tx", tx_w, 5'h1F);
            chk("idle_tick_busy", busy_w, 0);
        end
        begin_frame(0, 8'h55);
        run_frame(0, 8'h55, 1'b1, 1'b0);
        settle(0);
        begin_frame(1, 8'h07);
        run_frame(1, 8'h07, 1'b0, 1'b0);
        settle(1);
        begin_frame(2, 8'h07);
        run_frame(2, 8'h07, 1'b1, 1'b0);
        settle(2);
        begin_frame(3, 8'hA3);
        run_frame(3, 8'hA3, 1'b0, 1'b0);
        settle(3);
        d = 8'($urandom);
        begin_frame(4, d);
        run_frame(4, d, 1'b0, 1'b0);
        settle(4);
        d = 8'($urandom);
        begin_frame(0, d);
        run_frame(0, d, 1'b0, 1'b1);
        begin_frame(0, 8'h34);
        run_frame(0, 8'h34, 1'b0, 1'b0);
        prev = 0;
        for (int f = 0; f < 8; f++) begin
            k = $urandom_range(0, 4);
            d = 8'($urandom);
            chain = (k == prev) && ($urandom_range(0, 1) == 1);
            if (!chain) settle(prev);
            begin_frame(k, d);
            run_frame(k, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            prev = k;
        end
        settle(prev);
        d = 8'($urandom);
        begin_frame(0, d);
        step();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 14; i++) step();
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
        end
        chk("pre_abort_bit3", tx_w[0], d[3]);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_tx", tx_w[0], 1);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_cs", cs_w[0], 0);
        chk("abort_done", done_w[0], 0);
        step();
        d = 8'($urandom);
        begin_frame(0, d);
        run_frame(0, d, 1'b0, 1'b0);
        settle(0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
